// File: rtl/tristate_updown_counter.sv
`default_nettype none
// ============================================================================
// Module  : tristate_updown_counter
// Brief   : Up/down counter that owns a shared tri-state bus through a
//           request/acknowledge FSM with a high-Z turnaround. Optional
//           SATURATE_COUNT_EN macro clamps at the ends instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
module tristate_updown_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      TURNAROUND  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic             drive_req,
  output logic             drive_ack,
  inout  wire  [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  localparam logic [3:0]       TURN_LAST = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [3:0]       turn_q,  turn_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= RESET_VALUE;
      turn_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    case (state_q)
      ST_IDLE: begin
        if (drive_req) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (!drive_req) begin
          turn_d  = 4'd0;
          state_d = (TURNAROUND == 0) ? ST_IDLE : ST_TURN;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          turn_d  = 4'd0;
          state_d = ST_IDLE;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        turn_d  = 4'd0;
      end
    endcase
  end

  // Load is only honoured in IDLE, so the bus is never our own value or mid-turnaround.
  always_comb begin
    count_d = count_q;
    if (load && (state_q == ST_IDLE)) begin
      count_d = bus;
    end else if (enable) begin
      if (up) begin
`ifdef SATURATE_COUNT_EN
        count_d = (count_q == ALL_ONES) ? count_q : count_q + ONE;
`else
        count_d = count_q + ONE;
`endif
      end else begin
`ifdef SATURATE_COUNT_EN
        count_d = (count_q == '0) ? count_q : count_q - ONE;
`else
        count_d = count_q - ONE;
`endif
      end
    end
  end

  assign drive_ack = (state_q == ST_DRIVE);
  assign bus       = (state_q == ST_DRIVE) ? count_q : {WIDTH{1'bz}};
  assign count     = count_q;
  assign tc        = up ? (count_q == ALL_ONES) : (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_tristate_updown_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tristate_updown_counter
// Brief   : Directed plus random stimulus against a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tristate_updown_counter;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'hE;
  localparam int         TA = 2;

  logic       clk = 1'b0;
  logic       rst_n, enable, up, load, drive_req;
  logic       drive_ack, tc;
  logic [3:0] count;
  wire  [3:0] bus;
  logic       tb_en;
  logic [3:0] tb_val;

  int checks = 0;
  int errors = 0;

  // Reference model: count as integer, ownership as "driving" flag plus turnaround cycles left.
  int m_count;
  bit m_drv;
  int m_turn;

  assign bus = tb_en ? tb_val : 4'bzzzz;

  always #5 clk = ~clk;

  tristate_updown_counter #(
    .WIDTH       (W),
    .RESET_VALUE (RV),
    .TURNAROUND  (TA)
  ) dut (
    .clock     (clk),
    .reset     (rst_n),
    .enable    (enable),
    .up        (up),
    .load      (load),
    .drive_req (drive_req),
    .drive_ack (drive_ack),
    .bus       (bus),
    .count     (count),
    .tc        (tc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_count(int c, bit u);
`ifdef SATURATE_COUNT_EN
    if (u) return (c == 15) ? 15 : c + 1;
    else   return (c == 0)  ? 0  : c - 1;
`else
    if (u) return (c + 1) % 16;
    else   return (c + 15) % 16;
`endif
  endfunction

  task automatic step(input bit r, input bit en, input bit u, input bit ld,
                      input bit rq, input logic [3:0] bv);
    bit idle;
    rst_n = r; enable = en; up = u; load = ld; drive_req = rq; tb_val = bv;
    @(posedge clk);
    if (!r) begin
      m_count = RV; m_drv = 1'b0; m_turn = 0;
    end else begin
      idle = !m_drv && (m_turn == 0);
      if (ld && idle)  m_count = int'(bv);
      else if (en)     m_count = next_count(m_count, u);
      if (idle)        m_drv = rq;
      else if (m_drv) begin
        if (!rq) begin m_drv = 1'b0; m_turn = TA; end
      end else         m_turn--;
    end
    #1 tb_en = !m_drv;
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("tc", 32'(tc), 32'(u ? (m_count == 15) : (m_count == 0)));
    chk("drive_ack", 32'(drive_ack), 32'(m_drv));
    if (m_drv) chk("bus_driven", 32'(bus), 32'(m_count));
    else       chk("bus_released", 32'(bus), 32'(tb_val));
  endtask

  initial begin
    tb_en = 1'b1; tb_val = 4'h0;
    rst_n = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; drive_req = 1'b0;
    m_count = RV; m_drv = 1'b0; m_turn = 0;

    // Reset and wrap: E, F, 0, 1
    step(0, 1, 1, 1, 1, 4'h7);
    chk("reset_count", 32'(count), 32'hE);
    chk("reset_ack", 32'(drive_ack), 32'h0);
    step(1, 1, 1, 0, 0, 4'h3); chk("wrap_F", 32'(count), 32'hF); chk("tc_at_F", 32'(tc), 32'h1);
    step(1, 1, 1, 0, 0, 4'h3); chk("wrap_0", 32'(count), 32'h0); chk("tc_at_0_up", 32'(tc), 32'h0);
    step(1, 1, 1, 0, 0, 4'h3); chk("wrap_1", 32'(count), 32'h1);

    // Down-count after load
    step(1, 0, 0, 1, 0, 4'h2); chk("load_2", 32'(count), 32'h2);
    step(1, 1, 0, 0, 0, 4'h6); chk("down_1", 32'(count), 32'h1);
    step(1, 1, 0, 0, 0, 4'h6); chk("down_0", 32'(count), 32'h0); chk("tc_at_0_down", 32'(tc), 32'h1);
    step(1, 1, 0, 0, 0, 4'h6);
`ifdef SATURATE_COUNT_EN
    chk("down_sat", 32'(count), 32'h0);
`else
    chk("down_wrap", 32'(count), 32'hF);
`endif

    // Drive and turnaround with TA=2
    step(1, 1, 1, 0, 1, 4'h0); chk("drv_ack1", 32'(drive_ack), 32'h1);
    step(1, 1, 1, 0, 1, 4'h0); chk("drv_ack2", 32'(drive_ack), 32'h1);
    step(1, 1, 1, 0, 1, 4'h0); chk("drv_bus", 32'(bus), 32'(count));
    step(1, 1, 1, 0, 1, 4'h0); chk("drv_ack4", 32'(drive_ack), 32'h1);
    step(1, 1, 1, 0, 0, 4'h9); chk("turn1_ack", 32'(drive_ack), 32'h0);
    step(1, 1, 1, 0, 1, 4'h9); chk("turn2_ack", 32'(drive_ack), 32'h0);
    step(1, 1, 1, 0, 1, 4'h9); chk("idle_ack", 32'(drive_ack), 32'h0);
    step(1, 1, 1, 0, 1, 4'h9); chk("redrive_ack", 32'(drive_ack), 32'h1);
    step(1, 0, 1, 0, 0, 4'h1);
    step(1, 0, 1, 0, 0, 4'h1);
    step(1, 0, 1, 0, 0, 4'h1);

    // Load with drive_req in IDLE, then load ignored while driving
    step(1, 0, 1, 1, 1, 4'h5); chk("load_drive_bus", 32'(bus), 32'h5);
    step(1, 0, 1, 1, 1, 4'hA); chk("load_ignored", 32'(count), 32'h5);
    step(1, 0, 1, 0, 0, 4'h1);
    step(1, 0, 1, 0, 0, 4'h1);
    step(1, 0, 1, 0, 0, 4'h1);

    // Reset mid-drive
    step(1, 0, 1, 1, 1, 4'h9); chk("pre_reset_bus", 32'(bus), 32'h9);
    step(0, 1, 1, 1, 1, 4'h4);
    chk("mid_reset_ack", 32'(drive_ack), 32'h0);
    chk("mid_reset_count", 32'(count), 32'hE);
    step(1, 0, 1, 0, 0, 4'hC); chk("post_reset_idle", 32'(drive_ack), 32'h0);

    // Load beats enable
    step(1, 1, 1, 1, 0, 4'h3); chk("load_priority", 32'(count), 32'h3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(31) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(3) == 0), ($urandom_range(2) != 0), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
